// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - NCH-channel programmable clock divider with glitch-free divisor updates
module clk_div_multi #(
  parameter int NCH      = 4,
  parameter int DIV_W    = 16,
  parameter int DIV_INIT = 4
) (
  input  logic             clk_tmp,
  input  logic             rst,
  input  logic             div_wr,
  input  logic [3:0]       div_ch,
  input  logic [DIV_W-1:0] div_val,
  input  logic             sync,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pend
);

  // Per-channel state: active divisor, counter, pending divisor and pending flag
  logic [DIV_W-1:0] n_q   [NCH];
  logic [DIV_W-1:0] n_d   [NCH];
  logic [DIV_W-1:0] cnt_q [NCH];
  logic [DIV_W-1:0] cnt_d [NCH];
  logic [DIV_W-1:0] p_q   [NCH];
  logic [DIV_W-1:0] p_d   [NCH];
  logic [NCH-1:0]   pend_q;
  logic [NCH-1:0]   pend_d;
  logic [NCH-1:0]   clk_out_q;
  logic [NCH-1:0]   clk_out_d;
  logic [NCH-1:0]   tick_q;
  logic [NCH-1:0]   tick_d;

  // Per-channel decode: end of period, apply point and write hit
  logic [NCH-1:0]   wrap;
  logic [NCH-1:0]   apply;
  logic [NCH-1:0]   wr_hit;

  // Next-state for every channel; outputs are derived from the next cnt/N so the
  // registered clk_out/tick line up with the counter value they describe
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      n_d[i]    = n_q[i];
      cnt_d[i]  = cnt_q[i];
      p_d[i]    = p_q[i];
      pend_d[i] = pend_q[i];

      // N=0 never wraps; it is handled as a disabled channel instead
      wrap[i]   = (n_q[i] != '0) && (cnt_q[i] == n_q[i] - DIV_W'(1));
      apply[i]  = pend_q[i] && (sync || wrap[i] || (n_q[i] == '0));
      // A channel index >= NCH can never match, so such writes fall away here
      wr_hit[i] = div_wr && (div_ch == 4'(i));

      if (apply[i]) begin
        n_d[i]    = p_q[i];
        pend_d[i] = 1'b0;
      end

      if (sync || apply[i] || wrap[i] || (n_q[i] == '0)) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DIV_W'(1);
      end

      // A write landing on the apply edge is kept pending for the next boundary
      if (wr_hit[i]) begin
        p_d[i]    = div_val;
        pend_d[i] = 1'b1;
      end

      clk_out_d[i] = (n_d[i] != '0) && (cnt_d[i] >= (n_d[i] >> 1));
      tick_d[i]    = (n_d[i] != '0) && (cnt_d[i] == n_d[i] - DIV_W'(1));
    end
  end

  // State and output registers; reset drops all progress and pending writes
  always_ff @(posedge clk_tmp or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        n_q[i]   <= DIV_W'(DIV_INIT);
        cnt_q[i] <= '0;
        p_q[i]   <= '0;
      end
      pend_q    <= '0;
      clk_out_q <= '0;
      tick_q    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        n_q[i]   <= n_d[i];
        cnt_q[i] <= cnt_d[i];
        p_q[i]   <= p_d[i];
      end
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pend    = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - scoreboard bench for clk_div_multi with random stimulus and reference model
module tb_clk_div_multi;

  localparam int NCH   = 4;
  localparam int DIV_W = 16;
  localparam int DINIT = 4;

  logic             clk_tmp;
  logic             rst;
  logic             div_wr;
  logic [3:0]       div_ch;
  logic [DIV_W-1:0] div_val;
  logic             sync;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   pend;

  clk_div_multi #(.NCH(NCH), .DIV_W(DIV_W), .DIV_INIT(DINIT)) dut (
    .clk_tmp (clk_tmp),
    .rst     (rst),
    .div_wr  (div_wr),
    .div_ch  (div_ch),
    .div_val (div_val),
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick),
    .pend    (pend)
  );

  initial begin
    clk_tmp = 1'b0;
    forever #5 clk_tmp = ~clk_tmp;
  end

  typedef struct packed {
    logic [NCH-1:0] c;
    logic [NCH-1:0] t;
    logic [NCH-1:0] p;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: divisor, position within the period, pending value/flag
  int mN   [NCH];
  int mPos [NCH];
  int mP   [NCH];
  bit mPend[NCH];

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      mN[i] = DINIT; mPos[i] = 0; mP[i] = 0; mPend[i] = 0;
    end
  endtask

  // Advance the model over one edge with the given inputs and queue the outputs it implies
  task automatic model_step(input bit wr, input int ch, input int val, input bit sy);
    exp_t e;
    for (int i = 0; i < NCH; i++) begin
      bit at_end;
      at_end = (mN[i] > 0) && (mPos[i] == mN[i] - 1);
      if (sy) begin
        mPos[i] = 0;
        if (mPend[i]) begin mN[i] = mP[i]; mPend[i] = 0; end
      end else if (mPend[i] && (mN[i] == 0 || at_end)) begin
        mN[i] = mP[i]; mPos[i] = 0; mPend[i] = 0;
      end else if (mN[i] == 0) begin
        mPos[i] = 0;
      end else begin
        mPos[i] = (mPos[i] + 1) % mN[i];
      end
      if (wr && ch == i) begin
        mP[i] = val; mPend[i] = 1;
      end
      e.c[i] = (mN[i] > 0) && (mPos[i] >= mN[i] / 2);
      e.t[i] = (mN[i] > 0) && (mPos[i] == mN[i] - 1);
      e.p[i] = mPend[i];
    end
    exp_q.push_back(e);
  endtask

  // Called at a falling edge: drive inputs for the coming rising edge, then wait a cycle
  task automatic step(input bit wr, input int ch, input int val, input bit sy);
    div_wr  = wr;
    div_ch  = 4'(ch);
    div_val = DIV_W'(val);
    sync    = sy;
    model_step(wr, ch, val, sy);
    @(negedge clk_tmp);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [NCH-1:0] got, input logic [NCH-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
    end
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset();
    div_wr = 0; sync = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_clk_out", clk_out, '0);
    chk("rst_tick", tick, '0);
    chk("rst_pend", pend, '0);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Monitor: after each rising edge pop the expected outputs and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_tmp);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("clk_out", clk_out, e.c);
        chk("tick", tick, e.t);
        chk("pend", pend, e.p);
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1; div_wr = 0; div_ch = 0; div_val = 0; sync = 0;
    model_reset();
    @(negedge clk_tmp);
    chk("init_clk_out", clk_out, '0);
    chk("init_tick", tick, '0);
    chk("init_pend", pend, '0);
    rst = 1'b0;

    // Free run at the reset divisor
    idle(12);
    // ch1 -> 3
    step(1, 1, 3, 0);
    idle(10);
    // ch2 disabled, then re-enabled with 5
    step(1, 2, 0, 0);
    idle(6);
    step(1, 2, 5, 0);
    idle(10);
    // Two writes to ch0 in one period: only the last applies
    step(1, 0, 6, 0);
    step(1, 0, 2, 0);
    idle(10);
    // Write exactly on the apply cycle of ch0
    step(1, 0, 3, 0);
    guard = 0;
    while (!(mPend[0] && mN[0] > 0 && mPos[0] == mN[0] - 1) && guard < 40) begin
      step(0, 0, 0, 0);
      guard++;
    end
    total++;
    if (guard >= 40) begin
      bad++;
      $display("FAIL apply_cycle_search cyc=%0d got=timeout want=found", cyc);
    end
    step(1, 0, 5, 0);
    idle(12);
    // Different divisors, then sync with a same-cycle write
    step(1, 3, 7, 0);
    idle(9);
    step(1, 1, 6, 1);
    idle(20);
    // Out-of-range channel write
    step(1, 7, 1, 0);
    idle(6);
    // Reset with a write pending mid-period
    step(1, 2, 9, 0);
    async_reset();
    idle(10);

    // Random phase
    for (int k = 0; k < 3000; k++) begin
      bit wr, sy;
      int ch, val;
      if (k == 1500) async_reset();
      wr  = ($urandom % 4) == 0;
      ch  = $urandom % 8;
      val = (($urandom % 12) == 0) ? ($urandom % 300) : ($urandom % 9);
      sy  = ($urandom % 60) == 0;
      step(wr, ch, val, sy);
    end

    div_wr = 0; sync = 0;
    repeat (3) @(negedge clk_tmp);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised multi-channel clock divider. Generalises the fixed divide-by-4 toggle divider to NCH independent channels.
- Each channel has a runtime-programmable divisor and produces a divided clock (clk_out) and a one-cycle terminal-count strobe (tick).
- Divisor changes are glitch-free: a new value takes effect only at the channel's period boundary.
- A global sync input phase-aligns all channels. The block sits between the board clock domain and game-logic consumers such as display refresh, debounce and timers.

Parameters:
- NCH, 4, number of independent divider channels (1..16).
- DIV_W, 16, divisor and counter width in bits.
- DIV_INIT, 4, divisor loaded into every channel at reset; must be >= 2.

Ports:
- clk_tmp  in   1          block clock; all state updates on its rising edge.
- rst      in   1          reset, asynchronous, active-high.
- div_wr   in   1          divisor write strobe, one clk_tmp cycle per write.
- div_ch   in   4          target channel index for div_wr.
- div_val  in   DIV_W      new divisor; 0 disables the channel.
- sync     in   1          one-cycle pulse; restarts all channels in phase.
- clk_out  out  NCH        divided clock per channel (registered).
- tick     out  NCH        terminal-count strobe per channel (registered).
- pend     out  NCH        per channel: written divisor not yet applied.

Behaviour:
- Per channel state: active divisor N (DIV_W), counter cnt (DIV_W), pending divisor P (DIV_W), pending flag pend.
- Reset (async, immediate):
  - N=DIV_INIT, cnt=0, P=0, pend=0.
  - clk_out=0, tick=0 for all channels.
  - Reset mid-period or mid-pending discards all progress and pending writes.
- Counting, N >= 1: cnt runs 0,1,..,N-1,0,... with one step per clk_tmp edge.
- Outputs are flops, valid in the same cycle as the cnt value they describe:
  - clk_out[i] = (cnt >= N>>1).
  - tick[i] = (cnt == N-1).
- Waveform results:
  - Period = N cycles; low for floor(N/2) cycles, high for ceil(N/2) cycles.
  - N=2 gives a plain toggle. N=1 gives clk_out held 1 and tick held 1.
- Disabled channel (N=0): cnt held 0, clk_out=0, tick=0.
- Divisor write (div_wr=1, div_ch<NCH):
  - P[div_ch]=div_val and pend=1, visible the next cycle.
  - div_ch>=NCH: write ignored, no state change.
  - A write while pend=1 overwrites P; only the last value is applied.
- Apply point (per channel): the cycle in which cnt==N-1 with pend=1, or any cycle with pend=1 and N=0.
  - At that edge: N<=P, cnt<=0, pend<=0.
  - The outputs then follow the new N from cnt=0, so no runt pulse occurs.
- Write to a channel in the same cycle as its apply point:
  - The previously pending P is applied.
  - The new div_val is stored as P with pend kept at 1, and applies at the next boundary.
- sync=1 (one cycle):
  - Every channel: cnt<=0.
  - Any channel with pend=1 applies P, with pend<=0.
  - sync overrides a simultaneous wrap.
  - A div_wr in the same cycle is stored as pending, not applied.
- Width rules:
  - Compare N-1 in DIV_W bits; N=0 is handled by the disabled rule, never by wrap.
  - Maximum period 2^DIV_W - 1.
- Channels are fully independent apart from the shared write port and sync.

Test Plan:
- Release rst with DIV_INIT=4, no writes -> every clk_out = 0,0,1,1 repeating; tick high on every 4th cycle (cnt=3); pend=0.
- Write ch1 div_val=3 at cnt=1 -> pend[1]=1 next cycle; channel finishes the old period (cnt 2,3) and then runs period 3 (clk_out 0,1,1); pend[1] clears at the apply edge; other channels unchanged.
- Write ch2 div_val=0, then later write div_val=5 -> ch2 goes 0/0 at its next boundary; the second write applies one cycle later (N=0 rule) giving pattern 0,0,1,1,1.
- Write ch0 twice (6 then 2) within one period -> only 2 is applied at the boundary; write in the exact tick cycle -> old P applied, new value pending.
- Channels at different phases, pulse sync -> next cycle all cnt=0, all clk_out=0, and ticks realign to common multiples of the divisors; div_ch=7 write with NCH=4 -> no effect.
- Assert rst mid-period with pend=1 -> outputs 0 immediately without a clock edge, pend=0, N back to DIV_INIT.
